// File: rtl/alu_op_sequencer_if.sv
// Command and response streams between a command source and alu_op_sequencer.
// master = command source / result consumer, slave = the sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_load;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_load, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_load, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU from registered operands, folds each result
// into an accumulator with carry/zero flags, and returns it on a backpressured stream.
module alu_op_sequencer #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_sel,
    output logic               alu_cin,
    input  logic [WIDTH-1:0]   alu_y,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       sel_q;
    logic             carry;
    logic             carry_next;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_carry_q;
    logic             res_zero_q;

    // Carry is only meaningful for the increment and add ops; everything else keeps it.
    always_comb begin
        carry_next = carry;
        unique case (sel_q)
            4'b0001: carry_next = (acc == '1);
            4'b0110: carry_next = (alu_y < acc);
            4'b0111: carry_next = (alu_y < acc) || (carry && (alu_y == acc));
            default: carry_next = carry;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= ACC_INIT;
            carry       <= 1'b0;
            b_q         <= '0;
            sel_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        sel_q <= bus.cmd_op;
                        b_q   <= bus.cmd_data;
                        if (bus.cmd_load) begin
                            acc         <= bus.cmd_data;
                            res_data_q  <= bus.cmd_data;
                            res_carry_q <= carry;
                            res_zero_q  <= (bus.cmd_data == '0);
                            res_valid_q <= 1'b1;
                            state       <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    acc         <= alu_y;
                    carry       <= carry_next;
                    res_data_q  <= alu_y;
                    res_carry_q <= carry_next;
                    res_zero_q  <= (alu_y == '0);
                    res_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_a   = acc;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;
    assign alu_cin = carry;

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU stand-in plus an accumulator/carry
// reference model computed with wide integer arithmetic.
module tb_alu_op_sequencer;

    localparam int unsigned      W    = 8;
    localparam logic [W-1:0]     INIT = 8'h00;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic [3:0]   alu_sel;
    logic         alu_cin;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ref_acc;
    logic         ref_carry;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();

    alu_op_sequencer #(.WIDTH(W), .ACC_INIT(INIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_cin (alu_cin),
        .alu_y   (alu_y),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the team ALU.
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        case (op)
            4'h0: return a;
            4'h1: return a + W'(1);
            4'h2: return a - W'(1);
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a ^ b;
            4'h6: return a + b;
            4'h7: return a + b + W'(cin);
            4'h8: return ~a;
            4'h9: return b;
            4'hA: return a - b;
            4'hB: return a << 1;
            4'hC: return a >> 1;
            4'hD: return ~b;
            4'hE: return '0;
            default: return '1;
        endcase
    endfunction

    always_comb alu_y = alu_fn(alu_sel, alu_a, alu_b, alu_cin);

    task automatic model_reset();
        ref_acc   = INIT;
        ref_carry = 1'b0;
    endtask

    // Carry = true unsigned overflow of the mathematical sum.
    task automatic model_step(input logic [3:0] op, input logic [W-1:0] d, input bit ld,
                              output logic [W-1:0] ed, output logic ec, output logic ez);
        int unsigned sum;
        logic [W-1:0] y;
        if (ld) begin
            ref_acc = d;
        end else begin
            y = alu_fn(op, ref_acc, d, ref_carry);
            sum = 0;
            if (op == 4'h1) sum = ref_acc + 1;
            if (op == 4'h6) sum = ref_acc + d;
            if (op == 4'h7) sum = ref_acc + d + ref_carry;
            if (op == 4'h1 || op == 4'h6 || op == 4'h7) ref_carry = (sum >= (1 << W));
            ref_acc = y;
        end
        ed = ref_acc;
        ec = ref_carry;
        ez = (ref_acc == '0);
    endtask

    // Drives one command and consumes its response; starts and ends 1 time unit after an edge.
    task automatic do_txn(input logic [3:0] op, input logic [W-1:0] d, input bit ld,
                          input int ready_delay,
                          output logic [W-1:0] rd, output logic rc, output logic rz,
                          output int lat, output logic [W-1:0] ia, output logic icin,
                          output bit to);
        int n;
        to = 1'b0;
        lat = 0;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_load  = ld;
        bus.res_ready = (ready_delay == 0);
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.cmd_ready) begin
            to = 1'b1;
            bus.cmd_valid = 1'b0;
            bus.res_ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        ia   = alu_a;
        icin = alu_cin;
        lat  = 1;
        while (!bus.res_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.res_valid) to = 1'b1;
        rd = bus.res_data;
        rc = bus.res_carry;
        rz = bus.res_zero;
        for (int k = 0; k < ready_delay; k++) begin
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.res_data !== '0)    begin errors++; $display("FAIL reset_res_data: got %h expected 00", bus.res_data); end
        checks++; if ({bus.res_carry, bus.res_zero} !== 2'b00) begin errors++; $display("FAIL reset_res_flags: got %b%b expected 00", bus.res_carry, bus.res_zero); end
        checks++; if (alu_a !== INIT)         begin errors++; $display("FAIL reset_alu_a: got %h expected %h", alu_a, INIT); end
        checks++; if ({alu_b, alu_sel, alu_cin} !== '0) begin errors++; $display("FAIL reset_alu_ctrl: got b=%h sel=%h cin=%b expected zeros", alu_b, alu_sel, alu_cin); end
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [3:0]   ops [8] = '{4'h0, 4'h6, 4'h0, 4'h6, 4'h7, 4'h0, 4'h1, 4'h8};
        logic [W-1:0] ds  [8] = '{8'h05, 8'h03, 8'hF0, 8'h20, 8'h01, 8'hFF, 8'h00, 8'h00};
        bit           lds [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] rd, ia, ed, ea;
        logic rc, rz, icin, ec, ez, ecin;
        int lat;
        bit to;
        for (int i = 0; i < 8; i++) begin
            ea = ref_acc;
            ecin = ref_carry;
            model_step(ops[i], ds[i], lds[i], ed, ec, ez);
            do_txn(ops[i], ds[i], lds[i], i % 3, rd, rc, rz, lat, ia, icin, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir%0d_timeout: handshake did not complete", i); end
            checks++; if (rd !== ed) begin errors++; $display("FAIL dir%0d_data: got %h expected %h", i, rd, ed); end
            checks++; if ({rc, rz} !== {ec, ez}) begin errors++; $display("FAIL dir%0d_flags: got c=%b z=%b expected c=%b z=%b", i, rc, rz, ec, ez); end
            checks++; if (lat != (lds[i] ? 1 : 2)) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, lds[i] ? 1 : 2); end
            if (!lds[i]) begin
                checks++; if ({ia, icin} !== {ea, ecin}) begin errors++; $display("FAIL dir%0d_issue: got a=%h cin=%b expected a=%h cin=%b", i, ia, icin, ea, ecin); end
            end
        end
        checks++; if (alu_a !== 8'hFF) begin errors++; $display("FAIL dir_final_acc: got %h expected ff", alu_a); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ed, hd;
        logic ec, ez, hc, hz;
        int n;
        model_step(4'h6, 8'h11, 1'b0, ed, ec, ez);
        bus.cmd_op = 4'h6; bus.cmd_data = 8'h11; bus.cmd_load = 1'b0;
        bus.res_ready = 1'b0; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid: got %b expected 1", bus.res_valid); end
        hd = bus.res_data; hc = bus.res_carry; hz = bus.res_zero;
        checks++; if ({hd, hc, hz} !== {ed, ec, ez}) begin errors++; $display("FAIL bp_result: got %h c=%b z=%b expected %h c=%b z=%b", hd, hc, hz, ed, ec, ez); end
        bus.cmd_op = 4'h0; bus.cmd_data = 8'h99; bus.cmd_load = 1'b1; bus.cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if ({bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero} !== {1'b1, hd, hc, hz})
                begin errors++; $display("FAIL bp_hold%0d: got v=%b %h c=%b z=%b expected v=1 %h c=%b z=%b", k, bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero, hd, hc, hz); end
            checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready%0d: got %b expected 0", k, bus.cmd_ready); end
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", bus.res_valid, bus.cmd_ready); end
        bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy, alu_a} !== {1'b0, ref_acc}) begin errors++; $display("FAIL bp_no_accept: got busy=%b acc=%h expected busy=0 acc=%h", busy, alu_a, ref_acc); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] rd, ia, ed;
        logic rc, rz, icin, ec, ez;
        int lat;
        bit to;
        model_step(4'h0, 8'h40, 1'b1, ed, ec, ez);
        do_txn(4'h0, 8'h40, 1'b1, 0, rd, rc, rz, lat, ia, icin, to);
        checks++; if (rd !== 8'h40) begin errors++; $display("FAIL ar_load: got %h expected 40", rd); end
        // Reset in ISSUE.
        bus.cmd_op = 4'h6; bus.cmd_data = 8'h55; bus.cmd_load = 1'b0; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_issue_busy: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.res_valid, busy, bus.cmd_ready} !== 3'b001) begin errors++; $display("FAIL ar_issue_state: got valid=%b busy=%b ready=%b expected 0 0 1", bus.res_valid, busy, bus.cmd_ready); end
        checks++; if (alu_a !== INIT) begin errors++; $display("FAIL ar_issue_acc: got %h expected %h", alu_a, INIT); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        // Reset in RESP.
        bus.cmd_op = 4'h0; bus.cmd_data = 8'h33; bus.cmd_load = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL ar_resp_valid: got %b expected 1", bus.res_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.res_valid, busy, bus.res_data} !== {1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL ar_resp_drop: got valid=%b busy=%b data=%h expected 0 0 00", bus.res_valid, busy, bus.res_data); end
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        model_step(4'h6, 8'h01, 1'b0, ed, ec, ez);
        do_txn(4'h6, 8'h01, 1'b0, 1, rd, rc, rz, lat, ia, icin, to);
        checks++; if ({to, rd, rc, rz} !== {1'b0, ed, ec, ez}) begin errors++; $display("FAIL ar_after: got to=%b %h c=%b z=%b expected to=0 %h c=%b z=%b", to, rd, rc, rz, ed, ec, ez); end
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL ar_after_value: got %h expected 01", rd); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d [6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        bit           exp_c [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] rd, ia, ed;
        logic rc, rz, icin, ec, ez;
        int lat, issued, got, last_cyc;
        bit to, drop;
        model_step(4'h0, 8'hFD, 1'b1, ed, ec, ez);
        do_txn(4'h0, 8'hFD, 1'b1, 0, rd, rc, rz, lat, ia, icin, to);
        checks++; if ({to, rd} !== {1'b0, 8'hFD}) begin errors++; $display("FAIL b2b_load: got to=%b %h expected to=0 fd", to, rd); end
        bus.cmd_op = 4'h1; bus.cmd_data = 8'h00; bus.cmd_load = 1'b0;
        bus.res_ready = 1'b1; bus.cmd_valid = 1'b1;
        issued = bus.cmd_ready ? 1 : 0;
        drop = 1'b0; got = 0; last_cyc = 0;
        for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
            @(posedge clk); #1;
            if (drop) bus.cmd_valid = 1'b0;
            if (bus.res_valid) begin
                model_step(4'h1, 8'h00, 1'b0, ed, ec, ez);
                checks++; if ({bus.res_data, bus.res_carry} !== {exp_d[got], exp_c[got]})
                    begin errors++; $display("FAIL b2b_res%0d: got %h c=%b expected %h c=%b", got, bus.res_data, bus.res_carry, exp_d[got], exp_c[got]); end
                checks++; if (bus.res_zero !== ez) begin errors++; $display("FAIL b2b_zero%0d: got %b expected %b", got, bus.res_zero, ez); end
                if (got > 0) begin
                    checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 3", got, cyc - last_cyc); end
                end
                last_cyc = cyc;
                got++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                issued++;
                if (issued == 6) drop = 1'b1;
            end
        end
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", got); end
        checks++; if ({busy, alu_a} !== {1'b0, 8'h03}) begin errors++; $display("FAIL b2b_final: got busy=%b acc=%h expected busy=0 acc=03", busy, alu_a); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [W-1:0] d, rd, ia, ed, ea;
        logic rc, rz, icin, ec, ez, ecin;
        bit ld, to;
        int lat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            d  = W'($urandom);
            ld = ($urandom_range(0, 4) == 0);
            ea = ref_acc;
            ecin = ref_carry;
            model_step(op, d, ld, ed, ec, ez);
            do_txn(op, d, ld, $urandom_range(0, 3), rd, rc, rz, lat, ia, icin, to);
            checks++; if ({to, rd, rc, rz} !== {1'b0, ed, ec, ez})
                begin errors++; $display("FAIL rnd%0d op=%h d=%h ld=%b: got to=%b %h c=%b z=%b expected to=0 %h c=%b z=%b", i, op, d, ld, to, rd, rc, rz, ed, ec, ez); end
            checks++; if (lat != (ld ? 1 : 2)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, ld ? 1 : 2); end
            if (!ld) begin
                checks++; if ({ia, icin} !== {ea, ecin}) begin errors++; $display("FAIL rnd%0d_issue: got a=%h cin=%b expected a=%h cin=%b", i, ia, icin, ea, ecin); end
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;
        bus.cmd_load  = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
